cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
Debug/run sequencer for the 8-bit 4-register tiny CPU core. Owns the core's clock-enable and PC-reset, loads program bytes into the 256-byte program memory through a write port, and supports run, N-instruction step, halt and a single PC breakpoint. Sits between the host-side command/load interface and the CPU core plus its program memory. Also keeps an executed-cycle counter.

Parameters:
ADDR_W, 8, program memory address width (must equal the CPU PC width)
DATA_W, 8, program memory word width
CYC_W, 16, width of the executed-cycle counter

Ports:
i_CLK  in  1  clock
i_RST  in  1  reset
i_CMD_VALID  in  1  command strobe
i_CMD  in  3  opcode: 000 NOP, 001 LOAD, 010 RUN, 011 STEP, 100 HALT, 101 SET_BP, 110 CLR_BP, 111 RESET_CPU
i_CMD_ARG  in  ADDR_W  LOAD start address / STEP count / SET_BP address
o_CMD_READY  out  1  command accepted when i_CMD_VALID & o_CMD_READY
i_LD_VALID  in  1  load byte strobe
i_LD_DATA  in  DATA_W  load byte
i_LD_LAST  in  1  marks final byte of a load burst
o_LD_READY  out  1  load byte accepted when i_LD_VALID & o_LD_READY
o_MEM_WE  out  1  program memory write enable
o_MEM_ADDR  out  ADDR_W  program memory write address
o_MEM_WDATA  out  DATA_W  program memory write data
i_PC  in  ADDR_W  current CPU PC
o_CPU_EN  out  1  CPU clock enable; core advances only on edges where this is 1
o_CPU_RST  out  1  synchronous PC/register-bank reset to the core
o_STATE  out  3  current state encoding
o_HALTED  out  1  1 when state is IDLE
o_BP_HIT  out  1  one-cycle pulse on breakpoint stop
o_CYCLES  out  CYC_W  count of cycles with o_CPU_EN=1

Behaviour:
- Clocking/reset: single clock i_CLK; i_RST is synchronous, active-high.
- Reset values: state IDLE (0), o_CPU_EN 0, o_CPU_RST 0, o_MEM_WE 0, o_MEM_ADDR 0, o_MEM_WDATA 0, o_BP_HIT 0, o_CYCLES 0, o_HALTED 1, breakpoint invalid, load address 0.
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, CPURST=4.
- o_CMD_READY = 1 in IDLE, RUN and STEP; 0 in LOAD and CPURST. In RUN/STEP only HALT acts; other accepted commands are consumed and ignored.
- IDLE: LOAD -> LOAD, with load address = i_CMD_ARG. RUN -> RUN. STEP -> STEP, with step counter = i_CMD_ARG (0 treated as 1). SET_BP latches the breakpoint address and sets it valid. CLR_BP invalidates the breakpoint. RESET_CPU -> CPURST. HALT/NOP have no effect.
- LOAD: o_LD_READY = 1. Each accepted byte produces o_MEM_WE=1 with o_MEM_ADDR = load address and o_MEM_WDATA = byte, registered, one cycle after the handshake.
  - Load address increments after each byte and wraps 255 -> 0.
  - A byte accepted with i_LD_LAST=1 -> IDLE next cycle; its write still issues in that cycle.
  - Back-to-back bytes give one write per cycle.
- RUN: o_CPU_EN = 1 every cycle except a breakpoint stop.
- Breakpoint stop (RUN or STEP): breakpoint valid & i_PC == bp address & not the first enabled cycle after entering RUN/STEP. The first-cycle skip lets execution resume from the breakpoint PC.
  - On a stop, o_CPU_EN is 0 that cycle (combinational on i_PC), o_BP_HIT pulses 1 the next cycle, state -> IDLE.
- STEP: o_CPU_EN = 1 for exactly N cycles, then IDLE. A breakpoint can end STEP early.
- HALT accepted in RUN/STEP at cycle t: o_CPU_EN follows normal RUN/STEP rules at t; state IDLE and o_CPU_EN 0 from t+1.
  - HALT and a breakpoint stop in the same cycle: the stop takes effect (o_CPU_EN 0 at t, o_BP_HIT pulses).
  - HALT on the last STEP cycle: IDLE at t+1, with no extra enable.
- CPURST: o_CPU_RST = 1 and o_CPU_EN = 0 for exactly 2 cycles; o_CYCLES cleared to 0; then IDLE. Breakpoint is retained.
- o_CYCLES increments on every cycle with o_CPU_EN=1 and saturates at 2^CYC_W-1.
- i_RST mid-operation (any state) forces the reset values above on the next edge. A pending LOAD write is dropped. The breakpoint is cleared.

Test Plan:
- Load: LOAD arg=0x10, stream bytes 0x21,0x13,0x34 (LAST on 3rd) -> writes (0x10,0x21),(0x11,0x13),(0x12,0x34) on consecutive cycles, each 1 cycle after its handshake; o_HALTED=1 after; o_CMD_READY=0 during LOAD.
- Wrap: LOAD arg=0xFF, two bytes -> write addresses 0xFF then 0x00.
- Step: STEP arg=3 from IDLE -> o_CPU_EN high exactly 3 cycles, o_CYCLES=3, back in IDLE; STEP arg=0 -> exactly 1 enabled cycle.
- Breakpoint: SET_BP 0x09, RUN with i_PC incrementing from 0 -> o_CPU_EN=0 in the cycle i_PC=0x09, o_BP_HIT pulses once, IDLE, o_CYCLES=9.
  - Then RUN again -> core advances past 0x09 (first-cycle skip).
- Halt priority: HALT during RUN -> no o_CPU_EN on the next cycle. HALT on the cycle i_PC hits bp -> o_BP_HIT=1, o_CPU_EN=0 that cycle.
- Reset/CPURST: RESET_CPU -> o_CPU_RST high 2 cycles, o_CYCLES=0. Assert i_RST mid-LOAD with a byte just accepted -> no o_MEM_WE next cycle, state IDLE, breakpoint invalid.

Source files
------------

// File: rtl/cpu_run_controller_if.sv
// Host/core-side bundle for cpu_run_controller.
//
// Groups the command port, the load-byte stream, the program-memory write port,
// the core control/observation lines and the status outputs. clk/rst are not
// part of the bundle.
//
// Modports:
//   slave  - the run controller itself (consumes commands, drives status/core).
//   master - the environment (host + CPU core) that drives commands/bytes/PC.
interface cpu_run_controller_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CYC_W  = 16
) ();

  // Command port
  logic              i_CMD_VALID;
  logic [2:0]        i_CMD;
  logic [ADDR_W-1:0] i_CMD_ARG;
  logic              o_CMD_READY;

  // Load-byte stream
  logic              i_LD_VALID;
  logic [DATA_W-1:0] i_LD_DATA;
  logic              i_LD_LAST;
  logic              o_LD_READY;

  // Program memory write port
  logic              o_MEM_WE;
  logic [ADDR_W-1:0] o_MEM_ADDR;
  logic [DATA_W-1:0] o_MEM_WDATA;

  // CPU core control / observation
  logic [ADDR_W-1:0] i_PC;
  logic              o_CPU_EN;
  logic              o_CPU_RST;

  // Status
  logic [2:0]        o_STATE;
  logic              o_HALTED;
  logic              o_BP_HIT;
  logic [CYC_W-1:0]  o_CYCLES;

  modport slave (
    input  i_CMD_VALID, i_CMD, i_CMD_ARG,
    output o_CMD_READY,
    input  i_LD_VALID, i_LD_DATA, i_LD_LAST,
    output o_LD_READY,
    output o_MEM_WE, o_MEM_ADDR, o_MEM_WDATA,
    input  i_PC,
    output o_CPU_EN, o_CPU_RST,
    output o_STATE, o_HALTED, o_BP_HIT, o_CYCLES
  );

  modport master (
    output i_CMD_VALID, i_CMD, i_CMD_ARG,
    input  o_CMD_READY,
    output i_LD_VALID, i_LD_DATA, i_LD_LAST,
    input  o_LD_READY,
    input  o_MEM_WE, o_MEM_ADDR, o_MEM_WDATA,
    output i_PC,
    input  o_CPU_EN, o_CPU_RST,
    input  o_STATE, o_HALTED, o_BP_HIT, o_CYCLES
  );

endinterface

// File: rtl/cpu_run_controller.sv
// Debug/run sequencer for the 8-bit 4-register tiny CPU core.
//
// Owns the core clock-enable and PC/register reset, streams program bytes into
// the program memory write port, and provides run, N-instruction step, halt, a
// single PC breakpoint and a saturating executed-cycle counter.
//
// Ports:
//   i_CLK  - clock
//   i_RST  - synchronous active-high reset
//   bus    - cpu_run_controller_if.slave:
//            command port   i_CMD_VALID/i_CMD/i_CMD_ARG/o_CMD_READY
//            load stream    i_LD_VALID/i_LD_DATA/i_LD_LAST/o_LD_READY
//            memory write   o_MEM_WE/o_MEM_ADDR/o_MEM_WDATA (registered)
//            core control   i_PC in, o_CPU_EN/o_CPU_RST out
//            status         o_STATE/o_HALTED/o_BP_HIT/o_CYCLES
//
// Commands: 0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 HALT, 5 SET_BP, 6 CLR_BP, 7 RESET_CPU.
// In RUN/STEP only HALT acts; other accepted commands are consumed and dropped.
module cpu_run_controller #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CYC_W  = 16
) (
  input logic                i_CLK,
  input logic                i_RST,
  cpu_run_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StRun    = 3'd2,
    StStep   = 3'd3,
    StCpuRst = 3'd4
  } state_e;

  localparam logic [2:0] CmdNop    = 3'd0;
  localparam logic [2:0] CmdLoad   = 3'd1;
  localparam logic [2:0] CmdRun    = 3'd2;
  localparam logic [2:0] CmdStep   = 3'd3;
  localparam logic [2:0] CmdHalt   = 3'd4;
  localparam logic [2:0] CmdSetBp  = 3'd5;
  localparam logic [2:0] CmdClrBp  = 3'd6;
  localparam logic [2:0] CmdRstCpu = 3'd7;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic              bp_valid_q, bp_valid_d;
  logic [ADDR_W-1:0] step_cnt_q, step_cnt_d;
  // Set on entry to RUN/STEP; masks the breakpoint for the first enabled cycle
  // so execution can resume from a PC sitting on the breakpoint.
  logic              first_q, first_d;
  logic              bp_hit_q, bp_hit_d;
  logic              rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]  cycles_q, cycles_d;

  logic cmd_ready;
  logic cmd_fire;
  logic halt_fire;
  logic ld_ready;
  logic ld_fire;
  logic bp_match;
  logic cpu_en;
  logic cpu_rst;
  logic clr_cycles;

  assign cmd_ready = (state_q == StIdle) || (state_q == StRun) || (state_q == StStep);
  assign cmd_fire  = bus.i_CMD_VALID && cmd_ready;
  assign halt_fire = cmd_fire && (bus.i_CMD == CmdHalt);
  assign ld_ready  = (state_q == StLoad);
  assign ld_fire   = bus.i_LD_VALID && ld_ready;
  // Combinational on i_PC so the enable drops in the very cycle the PC matches.
  assign bp_match  = bp_valid_q && (bus.i_PC == bp_addr_q) && !first_q;

  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bp_addr_d   = bp_addr_q;
    bp_valid_d  = bp_valid_q;
    step_cnt_d  = step_cnt_q;
    first_d     = first_q;
    bp_hit_d    = 1'b0;
    rst_cnt_d   = rst_cnt_q;
    cpu_en      = 1'b0;
    cpu_rst     = 1'b0;
    clr_cycles  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          case (bus.i_CMD)
            CmdLoad: begin
              state_d   = StLoad;
              ld_addr_d = bus.i_CMD_ARG;
            end
            CmdRun: begin
              state_d = StRun;
              first_d = 1'b1;
            end
            CmdStep: begin
              state_d    = StStep;
              first_d    = 1'b1;
              step_cnt_d = (bus.i_CMD_ARG == '0) ? ADDR_W'(1) : bus.i_CMD_ARG;
            end
            CmdSetBp: begin
              bp_addr_d  = bus.i_CMD_ARG;
              bp_valid_d = 1'b1;
            end
            CmdClrBp: bp_valid_d = 1'b0;
            CmdRstCpu: begin
              state_d   = StCpuRst;
              rst_cnt_d = 1'b0;
            end
            CmdNop, CmdHalt: ;
            default: ;
          endcase
        end
      end

      StLoad: begin
        if (ld_fire) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ld_addr_q;
          mem_wdata_d = bus.i_LD_DATA;
          ld_addr_d   = ld_addr_q + 1'b1;  // wraps at the top of memory
          if (bus.i_LD_LAST) begin
            state_d = StIdle;
          end
        end
      end

      StRun: begin
        first_d = 1'b0;
        cpu_en  = !bp_match;
        // A breakpoint stop wins over a simultaneous HALT so the hit is reported.
        if (bp_match) begin
          state_d  = StIdle;
          bp_hit_d = 1'b1;
        end else if (halt_fire) begin
          state_d = StIdle;
        end
      end

      StStep: begin
        first_d = 1'b0;
        cpu_en  = !bp_match;
        if (bp_match) begin
          state_d  = StIdle;
          bp_hit_d = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q - 1'b1;
          if (step_cnt_q == ADDR_W'(1) || halt_fire) begin
            state_d = StIdle;
          end
        end
      end

      StCpuRst: begin
        cpu_rst    = 1'b1;
        clr_cycles = 1'b1;
        rst_cnt_d  = 1'b1;
        if (rst_cnt_q) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cycles_d = cycles_q;
    if (clr_cycles) begin
      cycles_d = '0;
    end else if (cpu_en && (cycles_q != {CYC_W{1'b1}})) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StIdle;
      ld_addr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bp_addr_q   <= '0;
      bp_valid_q  <= 1'b0;
      step_cnt_q  <= '0;
      first_q     <= 1'b0;
      bp_hit_q    <= 1'b0;
      rst_cnt_q   <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      ld_addr_q   <= ld_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bp_addr_q   <= bp_addr_d;
      bp_valid_q  <= bp_valid_d;
      step_cnt_q  <= step_cnt_d;
      first_q     <= first_d;
      bp_hit_q    <= bp_hit_d;
      rst_cnt_q   <= rst_cnt_d;
      cycles_q    <= cycles_d;
    end
  end

  assign bus.o_CMD_READY = cmd_ready;
  assign bus.o_LD_READY  = ld_ready;
  assign bus.o_MEM_WE    = mem_we_q;
  assign bus.o_MEM_ADDR  = mem_addr_q;
  assign bus.o_MEM_WDATA = mem_wdata_q;
  assign bus.o_CPU_EN    = cpu_en;
  assign bus.o_CPU_RST   = cpu_rst;
  assign bus.o_STATE     = state_q;
  assign bus.o_HALTED    = (state_q == StIdle);
  assign bus.o_BP_HIT    = bp_hit_q;
  assign bus.o_CYCLES    = cycles_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a table of per-cycle vectors followed by
// hand-written sequences for breakpoint, halt-priority and reset corner cases.
module tb_cpu_run_controller;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, RUN = 3'd2, STEP = 3'd3;
  localparam logic [2:0] HALT = 3'd4, SETBP = 3'd5, CLRBP = 3'd6, RSTC = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_controller_if #(.ADDR_W(8), .DATA_W(8), .CYC_W(16)) bus ();

  cpu_run_controller #(.ADDR_W(8), .DATA_W(8), .CYC_W(16)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       cv;
    logic [2:0] cmd;
    logic [7:0] arg;
    logic       lv;
    logic [7:0] ld;
    logic       last;
    logic [7:0] pc;
    logic [2:0] st;
    logic       en;
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       hit;
    logic [15:0] cyc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic cv, input logic [2:0] cmd, input logic [7:0] arg,
                              input logic lv, input logic [7:0] ld, input logic last,
                              input logic [7:0] pc, input logic [2:0] st, input logic en,
                              input logic we, input logic [7:0] wa, input logic [7:0] wd,
                              input logic hit, input logic [15:0] cyc);
    vec_t v;
    v = '{cv, cmd, arg, lv, ld, last, pc, st, en, we, wa, wd, hit, cyc};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [2:0] cmd, input logic [7:0] arg,
                       input logic lv, input logic [7:0] ld, input logic last,
                       input logic [7:0] pc);
    bus.i_CMD_VALID = cv;
    bus.i_CMD       = cmd;
    bus.i_CMD_ARG   = arg;
    bus.i_LD_VALID  = lv;
    bus.i_LD_DATA   = ld;
    bus.i_LD_LAST   = last;
    bus.i_PC        = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] observed();
    return {bus.o_STATE, bus.o_CMD_READY, bus.o_LD_READY, bus.o_CPU_EN, bus.o_CPU_RST,
            bus.o_HALTED, bus.o_MEM_WE, bus.o_MEM_ADDR, bus.o_MEM_WDATA, bus.o_BP_HIT,
            bus.o_CYCLES};
  endfunction

  // Ready/halted/cpu_rst follow directly from the expected state.
  function automatic logic [41:0] expected(input vec_t v);
    logic crdy, lrdy, crst, halted;
    crdy   = (v.st == 3'd0) || (v.st == 3'd2) || (v.st == 3'd3);
    lrdy   = (v.st == 3'd1);
    crst   = (v.st == 3'd4);
    halted = (v.st == 3'd0);
    return {v.st, crdy, lrdy, v.en, crst, halted, v.we, v.wa, v.wd, v.hit, v.cyc};
  endfunction

  initial begin
    // cv cmd arg | lv ld last | pc || st en we wa wd hit cyc
    add(1, LOAD, 8'h10, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, NOP,  8'h00, 1, 8'h21, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    add(1, RUN,  8'h00, 1, 8'h13, 0, 8'h00, 1, 0, 1, 8'h10, 8'h21, 0, 0);
    add(0, NOP,  8'h00, 1, 8'h34, 1, 8'h00, 1, 0, 1, 8'h11, 8'h13, 0, 0);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h12, 8'h34, 0, 0);
    add(1, LOAD, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h12, 8'h34, 0, 0);
    add(0, NOP,  8'h00, 1, 8'hAA, 0, 8'h00, 1, 0, 0, 8'h12, 8'h34, 0, 0);
    add(0, NOP,  8'h00, 1, 8'hBB, 1, 8'h00, 1, 0, 1, 8'hFF, 8'hAA, 0, 0);
    add(1, STEP, 8'h03, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h00, 8'hBB, 0, 0);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h00, 3, 1, 0, 8'h00, 8'hBB, 0, 0);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h01, 3, 1, 0, 8'h00, 8'hBB, 0, 1);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h02, 3, 1, 0, 8'h00, 8'hBB, 0, 2);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h03, 0, 0, 0, 8'h00, 8'hBB, 0, 3);
    add(1, STEP, 8'h00, 0, 8'h00, 0, 8'h03, 0, 0, 0, 8'h00, 8'hBB, 0, 3);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h03, 3, 1, 0, 8'h00, 8'hBB, 0, 3);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h04, 0, 0, 0, 8'h00, 8'hBB, 0, 4);
    add(1, RSTC, 8'h00, 0, 8'h00, 0, 8'h04, 0, 0, 0, 8'h00, 8'hBB, 0, 4);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h04, 4, 0, 0, 8'h00, 8'hBB, 0, 4);
    add(1, RUN,  8'h00, 0, 8'h00, 0, 8'h00, 4, 0, 0, 8'h00, 8'hBB, 0, 0);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hBB, 0, 0);
    add(1, RUN,  8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hBB, 0, 0);
    add(1, STEP, 8'h05, 0, 8'h00, 0, 8'h00, 2, 1, 0, 8'h00, 8'hBB, 0, 0);
    add(1, HALT, 8'h00, 0, 8'h00, 0, 8'h01, 2, 1, 0, 8'h00, 8'hBB, 0, 1);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h02, 0, 0, 0, 8'h00, 8'hBB, 0, 2);
    add(1, STEP, 8'h02, 0, 8'h00, 0, 8'h02, 0, 0, 0, 8'h00, 8'hBB, 0, 2);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h02, 3, 1, 0, 8'h00, 8'hBB, 0, 2);
    add(1, HALT, 8'h00, 0, 8'h00, 0, 8'h03, 3, 1, 0, 8'h00, 8'hBB, 0, 3);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h04, 0, 0, 0, 8'h00, 8'hBB, 0, 4);
    add(0, NOP,  8'h00, 0, 8'h00, 0, 8'h04, 0, 0, 0, 8'h00, 8'hBB, 0, 4);

    // Reset
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h00);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {bus.o_STATE, bus.o_HALTED, bus.o_CPU_EN, bus.o_CPU_RST, bus.o_MEM_WE,
                        bus.o_MEM_ADDR, bus.o_MEM_WDATA, bus.o_BP_HIT, bus.o_CYCLES},
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000});
    tick();

    // Table-driven vectors
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].cv, vq[i].cmd, vq[i].arg, vq[i].lv, vq[i].ld, vq[i].last, vq[i].pc);
      @(negedge clk);
      chk($sformatf("vec%0d", i), observed(), expected(vq[i]));
      tick();
    end

    // Clear cycle counter, then breakpoint at 0x09 with a PC that follows o_CPU_EN
    drive(1, RSTC, 8'h00, 0, 8'h00, 0, 8'h00);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h00);
    tick();
    tick();
    @(negedge clk);
    chk("cpurst_done", {bus.o_STATE, bus.o_CPU_RST, bus.o_CYCLES}, {3'd0, 1'b0, 16'd0});
    tick();
    drive(1, SETBP, 8'h09, 0, 8'h00, 0, 8'h00);
    tick();
    drive(1, RUN, 8'h00, 0, 8'h00, 0, 8'h00);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'(k));
      @(negedge clk);
      chk($sformatf("bp_run_en_pc%0d", k), bus.o_CPU_EN, (k < 9) ? 1'b1 : 1'b0);
      tick();
    end
    @(negedge clk);
    chk("bp_stop", {bus.o_BP_HIT, bus.o_STATE, bus.o_CYCLES}, {1'b1, 3'd0, 16'd9});
    tick();
    @(negedge clk);
    chk("bp_pulse_once", bus.o_BP_HIT, 1'b0);
    tick();

    // Resume from the breakpoint PC
    drive(1, RUN, 8'h00, 0, 8'h00, 0, 8'h09);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h09);
    @(negedge clk);
    chk("resume_first_en", {bus.o_STATE, bus.o_CPU_EN}, {3'd2, 1'b1});
    tick();
    drive(1, HALT, 8'h00, 0, 8'h00, 0, 8'h0A);
    @(negedge clk);
    chk("resume_second_en", bus.o_CPU_EN, 1'b1);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h0B);
    @(negedge clk);
    chk("halt_after_resume", {bus.o_STATE, bus.o_CPU_EN, bus.o_BP_HIT}, {3'd0, 1'b0, 1'b0});
    tick();

    // HALT in the same cycle as a breakpoint match: the stop wins
    drive(1, RUN, 8'h00, 0, 8'h00, 0, 8'h05);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h05);
    @(negedge clk);
    chk("halt_bp_pre_en", bus.o_CPU_EN, 1'b1);
    tick();
    drive(1, HALT, 8'h00, 0, 8'h00, 0, 8'h09);
    @(negedge clk);
    chk("halt_bp_en_low", bus.o_CPU_EN, 1'b0);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h09);
    @(negedge clk);
    chk("halt_bp_hit", {bus.o_BP_HIT, bus.o_STATE}, {1'b1, 3'd0});
    tick();

    // Breakpoint ends a STEP early
    drive(1, STEP, 8'h0A, 0, 8'h00, 0, 8'h07);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h07);
    @(negedge clk);
    chk("step_bp_en7", bus.o_CPU_EN, 1'b1);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h09);
    @(negedge clk);
    chk("step_bp_en9", {bus.o_STATE, bus.o_CPU_EN}, {3'd3, 1'b0});
    tick();
    @(negedge clk);
    chk("step_bp_hit", {bus.o_BP_HIT, bus.o_STATE}, {1'b1, 3'd0});
    tick();

    // i_RST with a load byte accepted in the same cycle
    drive(1, LOAD, 8'h40, 0, 8'h00, 0, 8'h00);
    tick();
    drive(0, NOP, 8'h00, 1, 8'h55, 0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_load_ready", bus.o_LD_READY, 1'b1);
    tick();
    rst = 1'b0;
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h00);
    @(negedge clk);
    chk("rst_drop_write", {bus.o_MEM_WE, bus.o_STATE, bus.o_MEM_ADDR, bus.o_MEM_WDATA},
        {1'b0, 3'd0, 8'h00, 8'h00});
    tick();
    // Breakpoint must be gone: PC parked on 0x09 keeps running past the first cycle
    drive(1, RUN, 8'h00, 0, 8'h00, 0, 8'h09);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h09);
    tick();
    @(negedge clk);
    chk("rst_bp_cleared", {bus.o_STATE, bus.o_CPU_EN}, {3'd2, 1'b1});
    tick();
    drive(1, HALT, 8'h00, 0, 8'h00, 0, 8'h09);
    tick();
    drive(0, NOP, 8'h00, 0, 8'h00, 0, 8'h09);
    @(negedge clk);
    chk("final_halt", {bus.o_STATE, bus.o_BP_HIT}, {3'd0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
